lfsr8_checker: RTL and testbench
================================

LFSR8_CHECKER -- requirements
Module: lfsr8_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 16: consecutive correct predictions required to declare lock.
REQ-002 Parameter LOSS_THRESH, default 4: consecutive mispredictions while locked that drop lock.
REQ-003 Parameter ERR_W, default 16: width of the error counter.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset_n  input  1  reset is asynchronous and active-low.
REQ-006 bit_valid  input  1  qualifies bit_in; no state change on cycles where it is low.
REQ-007 bit_in  input  1  serial stream; each bit is the feedback bit shifted into the LSB of an lfsr8 generator (taps 8,6,5,4) on one enable.
REQ-008 clear_err  input  1  synchronous clear of err_count.
REQ-009 locked  output  1  registered; high while in LOCKED state.
REQ-010 err_pulse  output  1  registered one-cycle pulse per locked-mode mismatch.
REQ-011 err_count  output  ERR_W  registered saturating count of locked-mode mismatches.

Function
REQ-012 Internal 8-bit history sr; predicted bit p = sr[7]^sr[5]^sr[4]^sr[3]; match = (bit_in == p).
REQ-013 States: FILL, HUNT, LOCKED; every transition and counter update occurs only on cycles with bit_valid=1.
REQ-014 FILL: sr <= {sr[6:0],bit_in}, fill counter increments; on the 8th valid bit, go to HUNT with match counter 0.
REQ-015 HUNT: sr <= {sr[6:0],bit_in}; match with sr!=0 increments match counter; mismatch, or sr==0, clears match counter to 0.
REQ-016 HUNT: on the valid bit that brings the match counter to LOCK_COUNT, go to LOCKED; locked is high from the next clock edge.
REQ-017 LOCKED: sr <= {sr[6:0],p} (free-running on prediction), so a corrupted input bit does not corrupt sr.
REQ-018 LOCKED mismatch: err_pulse=1 for exactly the following cycle, err_count increments, miss counter increments.
REQ-019 LOCKED match: miss counter clears to 0; err_pulse=0.
REQ-020 LOCKED: on the mismatch that brings the miss counter to LOSS_THRESH, that error is counted and pulsed, state goes to FILL with fill, match and miss counters cleared, and locked falls on the next edge.
REQ-021 err_count saturates at 2^ERR_W-1 and never wraps; err_pulse still asserts on mismatches while saturated.
REQ-022 clear_err=1 sets err_count to 0 on the next edge; if it coincides with a mismatch, clear wins (count=0) and err_pulse still asserts.
REQ-023 clear_err affects neither state nor locked; it acts regardless of bit_valid.
REQ-024 err_pulse is 0 on every cycle not immediately following a locked-mode mismatch, including all bit_valid=0 cycles.
REQ-025 No mismatches are counted in FILL or HUNT.

Reset
REQ-026 While reset_n=0: state=FILL, sr=0, all internal counters=0, locked=0, err_pulse=0, err_count=0, taking effect immediately without a clock edge.
REQ-027 reset_n asserted mid-stream, including while LOCKED, aborts immediately to the REQ-026 values; after release, acquisition restarts from FILL.

Verification
REQ-028 Reset: drive reset_n=0 mid-LOCKED -> locked, err_pulse and err_count read 0 before the next clk edge.
REQ-029 Clean acquisition: feed a lfsr8 stream seeded 0x01 at defaults -> locked rises exactly one edge after valid bit 24 (8 fill + 16 matches) and not earlier; err_count=0.
REQ-030 Isolated error: once locked, invert one bit -> err_pulse high one cycle, err_count=1, locked stays 1, later clean bits give no further errors.
REQ-031 Loss of lock: once locked, invert 4 consecutive bits -> err_count=4, locked falls after the 4th; resume clean stream -> locked rises again after 24 more valid bits.
REQ-032 Degenerate input: 100 valid zero bits, then 100 with bit_valid toggling -> locked never asserts, err_count=0.
REQ-033 Saturation and clear with ERR_W=4: 20 isolated errors while locked -> err_count holds 15; clear_err coincident with the 21st error -> err_count=0, err_pulse=1.

Source files
------------

// File: rtl/lfsr8_checker.sv
// Serial lfsr8 (taps 8,6,5,4) stream checker: fills history, hunts for a run of
// correct predictions, then free-runs on its own prediction and counts mismatches.
module lfsr8_checker #(
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int MW  = $clog2(LOCK_COUNT + 1);
    localparam int MSW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        FILL,
        HUNT,
        LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         sr_q, sr_d;
    logic [2:0]         fill_q, fill_d;
    logic [MW-1:0]      match_q, match_d;
    logic [MSW-1:0]     miss_q, miss_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    logic pred;
    logic match;

    assign pred  = sr_q[7] ^ sr_q[5] ^ sr_q[4] ^ sr_q[3];
    assign match = (bit_in == pred);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (bit_valid) begin
            unique case (state_q)
                FILL: begin
                    sr_d   = {sr_q[6:0], bit_in};
                    fill_d = fill_q + 3'd1;
                    if (fill_q == 3'd7) begin
                        state_d = HUNT;
                        match_d = '0;
                    end
                end
                HUNT: begin
                    sr_d = {sr_q[6:0], bit_in};
                    // An all-zero history predicts zeros forever, so it never counts toward lock.
                    if (match && (sr_q != 8'd0)) begin
                        match_d = match_q + MW'(1);
                        if (match_q == MW'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    sr_d = {sr_q[6:0], pred};
                    if (!match) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != {ERR_W{1'b1}}) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        if (miss_q == MSW'(LOSS_THRESH - 1)) begin
                            state_d = FILL;
                            fill_d  = '0;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MSW'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = FILL;
            endcase
        end

        if (clear_err) begin
            err_count_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr8_checker.sv
// Directed bench for lfsr8_checker: a default instance plus an ERR_W=4 instance
// sharing the same stimulus so saturation can be observed on the narrow counter.
module tb_lfsr8_checker;

    logic        clk;
    logic        reset_n;
    logic        bit_valid;
    logic        bit_in;
    logic        clear_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        locked4;
    logic        err_pulse4;
    logic [3:0]  err_count4;

    logic [7:0]  gen;
    int          checks;
    int          failures;

    lfsr8_checker dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .clear_err (clear_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    lfsr8_checker #(.ERR_W(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .clear_err (clear_err),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_count (err_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference generator: feedback bit is both the stream output and the new LSB.
    task automatic nextGen(output logic b);
        b   = gen[7] ^ gen[5] ^ gen[4] ^ gen[3];
        gen = {gen[6:0], b};
    endtask

    task automatic sendBit(input logic v, input logic b, input logic c);
        bit_valid = v;
        bit_in    = b;
        clear_err = c;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_locked: got %0b expected 0", locked);
        end
        checks++;
        if (err_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_err_pulse: got %0b expected 0", err_pulse);
        end
        checks++;
        if (err_count !== 16'd0 || err_count4 !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_err_count: got %0d/%0d expected 0/0", err_count, err_count4);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_clean_acquisition();
        logic b;
        doReset();
        gen = 8'h01;
        for (int i = 1; i <= 24; i++) begin
            nextGen(b);
            sendBit(1'b1, b, 1'b0);
            checks++;
            if (locked !== (i == 24)) begin
                failures++;
                $display("[TB] FAIL clean_lock bit %0d: got %0b expected %0b", i, locked, (i == 24));
            end
            if (i == 12) begin
                sendBit(1'b0, 1'b1, 1'b0);
                sendBit(1'b0, 1'b0, 1'b0);
            end
        end
        checks++;
        if (err_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL clean_err_count: got %0d expected 0", err_count);
        end
    endtask

    task automatic test_isolated_error();
        logic b;
        for (int i = 0; i < 5; i++) begin
            nextGen(b);
            sendBit(1'b1, b, 1'b0);
            checks++;
            if (err_pulse !== 1'b0) begin
                failures++;
                $display("[TB] FAIL iso_pre_pulse: got %0b expected 0", err_pulse);
            end
        end
        nextGen(b);
        sendBit(1'b1, ~b, 1'b0);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
            failures++;
            $display("[TB] FAIL iso_error: pulse=%0b count=%0d locked=%0b expected 1/1/1",
                     err_pulse, err_count, locked);
        end
        sendBit(1'b0, 1'b0, 1'b0);
        checks++;
        if (err_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL iso_pulse_width: got %0b expected 0", err_pulse);
        end
        for (int i = 0; i < 10; i++) begin
            nextGen(b);
            sendBit(1'b1, b, 1'b0);
            checks++;
            if (err_pulse !== 1'b0) begin
                failures++;
                $display("[TB] FAIL iso_post_pulse: got %0b expected 0", err_pulse);
            end
        end
        checks++;
        if (err_count !== 16'd1 || locked !== 1'b1) begin
            failures++;
            $display("[TB] FAIL iso_after: count=%0d locked=%0b expected 1/1", err_count, locked);
        end
    endtask

    task automatic test_async_reset();
        logic b;
        nextGen(b);
        sendBit(1'b1, ~b, 1'b0);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 16'd2) begin
            failures++;
            $display("[TB] FAIL areset_pre: pulse=%0b count=%0d expected 1/2", err_pulse, err_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL areset_immediate: locked=%0b pulse=%0b count=%0d expected 0/0/0",
                     locked, err_pulse, err_count);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_loss_of_lock();
        logic b;
        for (int i = 1; i <= 24; i++) begin
            nextGen(b);
            sendBit(1'b1, b, 1'b0);
            checks++;
            if (locked !== (i == 24)) begin
                failures++;
                $display("[TB] FAIL relock_after_reset bit %0d: got %0b expected %0b", i, locked, (i == 24));
            end
        end
        for (int k = 1; k <= 4; k++) begin
            nextGen(b);
            sendBit(1'b1, ~b, 1'b0);
            checks++;
            if (err_pulse !== 1'b1 || err_count !== 16'(k) || locked !== (k < 4)) begin
                failures++;
                $display("[TB] FAIL loss_error %0d: pulse=%0b count=%0d locked=%0b expected 1/%0d/%0b",
                         k, err_pulse, err_count, locked, k, (k < 4));
            end
        end
        for (int i = 1; i <= 24; i++) begin
            nextGen(b);
            sendBit(1'b1, b, 1'b0);
            checks++;
            if (locked !== (i == 24) || err_pulse !== 1'b0) begin
                failures++;
                $display("[TB] FAIL loss_relock bit %0d: locked=%0b pulse=%0b expected %0b/0",
                         i, locked, err_pulse, (i == 24));
            end
        end
        checks++;
        if (err_count !== 16'd4) begin
            failures++;
            $display("[TB] FAIL loss_err_count: got %0d expected 4", err_count);
        end
    endtask

    task automatic test_degenerate();
        doReset();
        for (int i = 0; i < 200; i++) begin
            sendBit((i < 100) ? 1'b1 : 1'((i % 2) == 0), 1'b0, 1'b0);
            checks++;
            if (locked !== 1'b0) begin
                failures++;
                $display("[TB] FAIL degenerate_locked cycle %0d: got %0b expected 0", i, locked);
            end
        end
        checks++;
        if (err_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL degenerate_err_count: got %0d expected 0", err_count);
        end
    endtask

    task automatic test_saturation();
        logic b;
        doReset();
        gen = 8'h5A;
        for (int i = 0; i < 24; i++) begin
            nextGen(b);
            sendBit(1'b1, b, 1'b0);
        end
        checks++;
        if (locked4 !== 1'b1 || locked !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_lock: got %0b/%0b expected 1/1", locked4, locked);
        end
        for (int k = 1; k <= 20; k++) begin
            nextGen(b);
            sendBit(1'b1, ~b, 1'b0);
            checks++;
            if (err_pulse4 !== 1'b1 || err_count4 !== 4'((k > 15) ? 15 : k) || err_count !== 16'(k)) begin
                failures++;
                $display("[TB] FAIL sat_error %0d: pulse4=%0b count4=%0d count=%0d expected 1/%0d/%0d",
                         k, err_pulse4, err_count4, err_count, (k > 15) ? 15 : k, k);
            end
            nextGen(b);
            sendBit(1'b1, b, 1'b0);
        end
        nextGen(b);
        sendBit(1'b1, ~b, 1'b1);
        checks++;
        if (err_count4 !== 4'd0 || err_pulse4 !== 1'b1 || err_count !== 16'd0 || locked4 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_clear: count4=%0d pulse4=%0b count=%0d locked4=%0b expected 0/1/0/1",
                     err_count4, err_pulse4, err_count, locked4);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        gen      = 8'h01;
        test_reset();
        test_clean_acquisition();
        test_isolated_error();
        test_async_reset();
        test_loss_of_lock();
        test_degenerate();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
